// File: rtl/alu_branch_unit_if.sv
// -----------------------------------------------------------------------------
// alu_branch_unit_if
// Operand/decode bus between the EX-stage controller and alu_branch_unit.
//
// Signals (controller -> unit):
//   en          capture enable; low holds all unit outputs
//   ALUOp[1:0]  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
//   funct7      instruction bit 30
//   funct3[2:0] instruction bits 14:12
//   Branch      conditional-branch instruction in EX
//   A1[63:0]    operand 1 (rs1)
//   A2[63:0]    operand 2 (rs2 or immediate)
// Signals (unit -> controller, all registered):
//   ALU_control[3:0], Y[63:0], zero, s_less, u_less, Branch_jump
//
// Modports: master = controller side, slave = alu_branch_unit side.
// -----------------------------------------------------------------------------
interface alu_branch_unit_if;
   logic        en;
   logic [1:0]  ALUOp;
   logic        funct7;
   logic [2:0]  funct3;
   logic        Branch;
   logic [63:0] A1;
   logic [63:0] A2;
   logic [3:0]  ALU_control;
   logic [63:0] Y;
   logic        zero;
   logic        s_less;
   logic        u_less;
   logic        Branch_jump;

   modport master (
      output en, ALUOp, funct7, funct3, Branch, A1, A2,
      input  ALU_control, Y, zero, s_less, u_less, Branch_jump
   );

   modport slave (
      input  en, ALUOp, funct7, funct3, Branch, A1, A2,
      output ALU_control, Y, zero, s_less, u_less, Branch_jump
   );
endinterface

// File: rtl/alu_branch_unit.sv
// -----------------------------------------------------------------------------
// alu_branch_unit
// Execute-stage compute block of the 64-bit RISC-V pipeline. Decodes
// ALUOp/funct7/funct3 into a 4-bit operation, evaluates it on A1/A2, derives
// zero / signed-less / unsigned-less flags and resolves the conditional
// branch. Every output is captured in a single register stage (latency 1,
// throughput 1 per cycle).
//
// Ports:
//   clk    in   rising-edge clock
//   PCrst  in   synchronous active-high reset; clears every output to 0 and
//               has priority over bus.en
//   bus    slave modport of alu_branch_unit_if (operands, decode fields,
//               enable, and the registered results)
//
// Build option:
//   ALU_SHIFT_EN  when defined, SLL/SRL/SRA are implemented. When undefined no
//                 shifter is built: codes 0100/0101/0111 are still decoded and
//                 reported on ALU_control, but produce Y = 0 (so zero = 1).
// -----------------------------------------------------------------------------
module alu_branch_unit (
   input  logic               clk,
   input  logic               PCrst,
   alu_branch_unit_if.slave   bus
);

   // Operation codes carried on ALU_control
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   logic [3:0]  ctrl_s;
   logic [63:0] y_s;
   logic        zero_s;
   logic        s_less_s;
   logic        u_less_s;
   logic        cond_s;
   logic        jump_s;

   logic [3:0]  ctrl_r;
   logic [63:0] y_r;
   logic        zero_r;
   logic        s_less_r;
   logic        u_less_r;
   logic        jump_r;

   // Decode ALUOp/funct7/funct3 into the ALU operation code
   always_comb begin
      ctrl_s = OP_ADD;
      case (bus.ALUOp)
         2'b00: ctrl_s = OP_ADD;
         2'b01: ctrl_s = OP_SUB;
         default: begin
            case (bus.funct3)
               // funct7 selects SUB only for R-type; ADDI has no subtract form
               3'b000: begin
                  if ((bus.ALUOp == 2'b10) && bus.funct7) begin
                     ctrl_s = OP_SUB;
                  end else begin
                     ctrl_s = OP_ADD;
                  end
               end
               3'b001: ctrl_s = OP_SLL;
               3'b010: ctrl_s = OP_SLT;
               3'b011: ctrl_s = OP_SLTU;
               3'b100: ctrl_s = OP_XOR;
               3'b101: begin
                  if (bus.funct7) begin
                     ctrl_s = OP_SRA;
                  end else begin
                     ctrl_s = OP_SRL;
                  end
               end
               3'b110: ctrl_s = OP_OR;
               3'b111: ctrl_s = OP_AND;
               default: ctrl_s = OP_ADD;
            endcase
         end
      endcase
   end

   // Operand comparisons, independent of the selected operation
   always_comb begin
      s_less_s = ($signed(bus.A1) < $signed(bus.A2));
      u_less_s = (bus.A1 < bus.A2);
   end

   // ALU datapath; unused codes and (without the shifter) shift codes give 0
   always_comb begin
      y_s = 64'd0;
      case (ctrl_s)
         OP_AND:  y_s = bus.A1 & bus.A2;
         OP_OR:   y_s = bus.A1 | bus.A2;
         OP_ADD:  y_s = bus.A1 + bus.A2;
         OP_XOR:  y_s = bus.A1 ^ bus.A2;
         OP_SUB:  y_s = bus.A1 - bus.A2;
         OP_SLT:  y_s = {63'd0, s_less_s};
         OP_SLTU: y_s = {63'd0, u_less_s};
`ifdef ALU_SHIFT_EN
         OP_SLL:  y_s = bus.A1 << bus.A2[5:0];
         OP_SRL:  y_s = bus.A1 >> bus.A2[5:0];
         OP_SRA:  y_s = $unsigned($signed(bus.A1) >>> bus.A2[5:0]);
`endif
         default: y_s = 64'd0;
      endcase
      zero_s = (y_s == 64'd0);
   end

   // Branch judge: funct3 picks the condition, only honoured when Branch = 1
   always_comb begin
      cond_s = 1'b0;
      case (bus.funct3)
         3'b000:  cond_s = zero_s;
         3'b001:  cond_s = ~zero_s;
         3'b100:  cond_s = s_less_s;
         3'b101:  cond_s = ~s_less_s;
         3'b110:  cond_s = u_less_s;
         3'b111:  cond_s = ~u_less_s;
         default: cond_s = 1'b0;
      endcase
      jump_s = bus.Branch & cond_s;
   end

   // Output register stage: reset clears, enable captures, otherwise hold
   always_ff @(posedge clk) begin
      if (PCrst) begin
         ctrl_r   <= 4'd0;
         y_r      <= 64'd0;
         zero_r   <= 1'b0;
         s_less_r <= 1'b0;
         u_less_r <= 1'b0;
         jump_r   <= 1'b0;
      end else if (bus.en) begin
         ctrl_r   <= ctrl_s;
         y_r      <= y_s;
         zero_r   <= zero_s;
         s_less_r <= s_less_s;
         u_less_r <= u_less_s;
         jump_r   <= jump_s;
      end else begin
         ctrl_r   <= ctrl_r;
         y_r      <= y_r;
         zero_r   <= zero_r;
         s_less_r <= s_less_r;
         u_less_r <= u_less_r;
         jump_r   <= jump_r;
      end
   end

   assign bus.ALU_control = ctrl_r;
   assign bus.Y           = y_r;
   assign bus.zero        = zero_r;
   assign bus.s_less      = s_less_r;
   assign bus.u_less      = u_less_r;
   assign bus.Branch_jump = jump_r;

endmodule

// File: tb/tb_alu_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_branch_unit
// Self-checking bench for alu_branch_unit: directed cases plus randomized
// traffic compared against a behavioural reference model. The model honours
// the ALU_SHIFT_EN build option the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_branch_unit;

   logic clk;
   logic PCrst;
   alu_branch_unit_if bus ();

   alu_branch_unit dut (
      .clk   (clk),
      .PCrst (PCrst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected register contents
   logic [3:0]  e_ctrl;
   logic [63:0] e_y;
   logic        e_z, e_sl, e_ul, e_bj;

   // Compare one observed value with its expected value
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: decode by mnemonic table, evaluate with plain arithmetic
   task automatic model(input logic [1:0] aluop, input logic f7, input logic [2:0] f3,
                        input logic br, input logic [63:0] a1, input logic [63:0] a2,
                        output logic [3:0] op, output logic [63:0] y, output logic z,
                        output logic sl, output logic ul, output logic bj);
      logic [3:0] tab [8];
      logic [5:0] sh;
      logic       take [8];
      tab = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
      if (aluop == 2'b00)      op = 4'd2;
      else if (aluop == 2'b01) op = 4'd6;
      else begin
         op = tab[f3];
         if (f3 == 3'd0 && f7 && aluop == 2'b10) op = 4'd6;
         if (f3 == 3'd5 && f7) op = 4'd7;
      end
      ul = (a1 < a2);
      sl = (a1[63] != a2[63]) ? a1[63] : (a1 < a2);
      sh = a2[5:0];
      y = 64'd0;
      case (op)
         4'd0: y = a1 & a2;
         4'd1: y = a1 | a2;
         4'd2: y = a1 + a2;
         4'd3: y = a1 ^ a2;
         4'd6: y = a1 + (~a2) + 64'd1;
         4'd8: y = {63'd0, sl};
         4'd9: y = {63'd0, ul};
`ifdef ALU_SHIFT_EN
         4'd4: y = a1 << sh;
         4'd5: y = a1 >> sh;
         4'd7: y = (a1 >> sh) | (a1[63] ? ~(~64'd0 >> sh) : 64'd0);
`endif
         default: y = 64'd0;
      endcase
      z = (y == 64'd0);
      take = '{z, !z, 1'b0, 1'b0, sl, !sl, ul, !ul};
      bj = br && take[f3];
   endtask

   // Advance one clock: update expected state from current inputs, then check
   task automatic tick(input string tag);
      logic [3:0] op; logic [63:0] y; logic z, sl, ul, bj;
      model(bus.ALUOp, bus.funct7, bus.funct3, bus.Branch, bus.A1, bus.A2, op, y, z, sl, ul, bj);
      if (PCrst) begin
         e_ctrl = 4'd0; e_y = 64'd0; e_z = 1'b0; e_sl = 1'b0; e_ul = 1'b0; e_bj = 1'b0;
      end else if (bus.en) begin
         e_ctrl = op; e_y = y; e_z = z; e_sl = sl; e_ul = ul; e_bj = bj;
      end
      @(posedge clk);
      #1;
      check({tag, ".ctrl"}, {60'd0, bus.ALU_control}, {60'd0, e_ctrl});
      check({tag, ".y"},    bus.Y, e_y);
      check({tag, ".zero"}, {63'd0, bus.zero},   {63'd0, e_z});
      check({tag, ".sl"},   {63'd0, bus.s_less}, {63'd0, e_sl});
      check({tag, ".ul"},   {63'd0, bus.u_less}, {63'd0, e_ul});
      check({tag, ".bj"},   {63'd0, bus.Branch_jump}, {63'd0, e_bj});
   endtask

   task automatic drive(input logic [1:0] aluop, input logic f7, input logic [2:0] f3,
                        input logic br, input logic [63:0] a1, input logic [63:0] a2);
      bus.ALUOp = aluop; bus.funct7 = f7; bus.funct3 = f3;
      bus.Branch = br; bus.A1 = a1; bus.A2 = a2;
   endtask

   initial begin
      logic [63:0] k;
      logic        known;
      logic        bj_exp [8];
      e_ctrl = 4'd0; e_y = 64'd0; e_z = 1'b0; e_sl = 1'b0; e_ul = 1'b0; e_bj = 1'b0;

      // Reset with nonzero inputs for two cycles
      PCrst = 1'b1; bus.en = 1'b1;
      drive(2'b10, 1'b1, 3'b000, 1'b1, 64'h1234, 64'h1234);
      tick("reset0");
      tick("reset1");
      check("reset.y_const", bus.Y, 64'd0);
      PCrst = 1'b0;

      // R-type sweep over every funct3/funct7
      for (int f = 0; f < 16; f++) begin
         drive(2'b10, f[3], f[2:0], 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4);
         tick($sformatf("rtype_f7%0d_f3%0d", f[3], f[2:0]));
         known = 1'b1;
         k = 64'd0;
         case (f[3:0])
            4'b0000:          k = 64'hFFFF_FFFF_FFFF_FFF4;
            4'b1000:          k = 64'hFFFF_FFFF_FFFF_FFEC;
            4'b0010, 4'b1010: k = 64'd1;
            4'b0011, 4'b1011: k = 64'd0;
`ifdef ALU_SHIFT_EN
            4'b0001, 4'b1001: k = 64'hFFFF_FFFF_FFFF_FF00;
            4'b0101:          k = 64'h0FFF_FFFF_FFFF_FFFF;
            4'b1101:          k = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
            default:          known = 1'b0;
         endcase
         if (known) check($sformatf("rtype_const_%0d", f), bus.Y, k);
      end

      // I-type ADDI ignores funct7
      drive(2'b11, 1'b1, 3'b000, 1'b0, 64'd5, 64'd3);
      tick("itype");
      check("itype.y_const", bus.Y, 64'd8);
      check("itype.ctrl_const", {60'd0, bus.ALU_control}, 64'd2);

      // Branches with A1 = -1, A2 = 1
      bj_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int f = 0; f < 8; f++) begin
         drive(2'b01, 1'b0, f[2:0], 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
         tick($sformatf("br_neg_f3%0d", f));
         check($sformatf("br_neg_const_%0d", f), {63'd0, bus.Branch_jump}, {63'd0, bj_exp[f]});
      end
      drive(2'b01, 1'b0, 3'b000, 1'b1, 64'd7, 64'd7);
      tick("beq_eq");
      check("beq_eq.bj_const", {63'd0, bus.Branch_jump}, 64'd1);
      check("beq_eq.zero_const", {63'd0, bus.zero}, 64'd1);
      drive(2'b01, 1'b0, 3'b000, 1'b0, 64'd7, 64'd7);
      tick("beq_nobranch");
      check("beq_nobranch.bj_const", {63'd0, bus.Branch_jump}, 64'd0);

`ifndef ALU_SHIFT_EN
      // Without the shifter, SLL decodes but yields zero
      drive(2'b10, 1'b0, 3'b001, 1'b0, 64'd1, 64'd3);
      tick("noshift_sll");
      check("noshift.y_const", bus.Y, 64'd0);
      check("noshift.zero_const", {63'd0, bus.zero}, 64'd1);
      check("noshift.ctrl_const", {60'd0, bus.ALU_control}, 64'd4);
`endif

      // Hold: en low with changing inputs
      drive(2'b10, 1'b0, 3'b100, 1'b0, 64'hA5A5, 64'h0F0F);
      tick("pre_hold");
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, i[0], 3'(i), 1'b1, 64'd100 + 64'(i), 64'd3);
         tick($sformatf("hold%0d", i));
         check($sformatf("hold%0d.y_const", i), bus.Y, 64'hAAAA);
      end

      // Reset has priority over enable
      bus.en = 1'b1; PCrst = 1'b1;
      drive(2'b00, 1'b0, 3'b000, 1'b1, 64'd9, 64'd9);
      tick("prio");
      check("prio.y_const", bus.Y, 64'd0);
      PCrst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [63:0] a1, a2;
         a1 = {$urandom, $urandom};
         a2 = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: ;
            1: begin a1 = 64'($urandom_range(0, 15)); a2 = 64'($urandom_range(0, 15)); end
            2: a2 = a1;
            default: begin a1 = {1'b1, 63'($urandom)}; a2 = {1'b0, 63'($urandom)}; end
         endcase
         if ($urandom_range(0, 1) == 0) a2 = {58'($urandom), 6'($urandom)};
         drive(2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), a1, a2);
         bus.en = ($urandom_range(0, 9) != 0);
         PCrst  = ($urandom_range(0, 39) == 0);
         tick($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
